svc_axi_rd_burst_split: RTL
===========================

// Module: svc_axi_rd_burst_split
//
// PURPOSE
// Read-channel AXI4 burst splitter; sits directly upstream of svc_axi_stripe.
// Breaks each incoming INCR read burst into sub-bursts that never cross a
// CHUNK_BEATS-aligned boundary, so every downstream burst is stripe-aligned.
// Forwards R beats in order and merges them back into one burst toward the
// manager, asserting rlast only on the final beat of the original burst.
//
// PARAMETERS
// AXI_ADDR_WIDTH  8   address width (AW)
// AXI_DATA_WIDTH  16  data width (DW), bytes per beat = DW/8
// AXI_ID_WIDTH    4   ID width (IDW)
// CHUNK_BEATS     4   max sub-burst beats / alignment unit; power of 2, 1..256
//
// PORTS
// clk            in   1       clock
// rst            in   1       synchronous reset, active-high
// s_axi_arvalid  in   1       upstream AR valid
// s_axi_arid     in   IDW     upstream AR id
// s_axi_araddr   in   AW      upstream AR byte address
// s_axi_arlen    in   8       upstream AR length (beats-1)
// s_axi_arsize   in   3       must equal $clog2(DW/8)
// s_axi_arburst  in   2       must be INCR (2'b01)
// s_axi_arready  out  1       upstream AR ready
// s_axi_rvalid   out  1       upstream R valid
// s_axi_rid      out  IDW     upstream R id
// s_axi_rdata    out  DW      upstream R data
// s_axi_rresp    out  2       upstream R resp
// s_axi_rlast    out  1       upstream R last (original burst)
// s_axi_rready   in   1       upstream R ready
// m_axi_ar*      out  -       downstream AR (same fields/widths as s_axi_ar*)
// m_axi_arready  in   1       downstream AR ready
// m_axi_r*       in   -       downstream R (same fields/widths as s_axi_r*)
// m_axi_rready   out  1       downstream R ready
//
// BEHAVIOUR
// - Reset: state IDLE; s_axi_arready=0 in reset cycle, 1 after; m_axi_arvalid=0;
//   beat/sub counters 0; all registered m_axi_ar* fields 0.
// - One original burst in flight. s_axi_arready=1 only in IDLE.
// - FSM: IDLE -(AR accept)-> ISSUE -(last sub-AR accepted)-> DRAIN
//   -(s_axi_rvalid && s_axi_rready && s_axi_rlast)-> IDLE.
//   If the final R beat handshakes in the same cycle the last sub-AR is
//   accepted, go straight to IDLE.
// - AR accept in cycle N: latch id/size/burst, addr, remaining = arlen+1
//   (9-bit). First m_axi_arvalid in cycle N+1 (registered).
// - Sub-burst length: beats = min(remaining, CHUNK_BEATS - ((addr>>size) %
//   CHUNK_BEATS)); m_axi_arlen = beats-1. On m_axi_arvalid && m_axi_arready:
//   addr += beats*(DW/8), remaining -= beats, subs_issued++. Next sub-AR
//   presented the following cycle. m_axi_arvalid/fields held stable while
//   stalled.
// - m_axi_arid/arsize/arburst copy the latched upstream values.
// - R path combinational pass-through: s_axi_rvalid=m_axi_rvalid,
//   m_axi_rready=s_axi_rready, rid/rdata/rresp copied. R may flow during ISSUE.
// - s_axi_rlast = m_axi_rlast && (subs_done == subs_total-1) && state!=ISSUE
//   -(all sub-ARs issued); subs_done increments on each downstream rlast
//   handshake.
// - rresp passed per beat unmodified (SLVERR/DECERR not masked or merged).
// - Unsupported arsize/arburst: behaviour undefined; bench must not drive.
// - Chunks are aligned and <=4KB, so no sub-burst crosses a 4KB boundary.
// - Reset mid-burst: all state discarded, m_axi_arvalid dropped same edge;
//   downstream must be reset together.
//
// TESTING (DW=16, CHUNK_BEATS=4, 8-byte chunk)
// - Aligned: AR addr 0xA0 len 3 id 0xD -> one sub-AR 0xA0 len 3; 4 R beats,
//   rlast on 4th only, rid 0xD.
// - Unaligned: AR addr 0xA4 len 3 -> sub-ARs (0xA4,len 1),(0xA8,len 1);
//   downstream rlast on beats 2,4; upstream rlast on beat 4 only.
// - Long: AR addr 0x00 len 8 -> sub-ARs (0x00,3),(0x08,3),(0x10,0);
//   9 beats, data order preserved, single rlast.
// - Single beat: AR addr 0x06 len 0 -> one sub-AR 0x06 len 0; rlast beat 1.
// - Backpressure: m_axi_arready low 3 cycles, s_axi_rready toggling -> AR
//   fields stable, no beat lost/duplicated, s_axi_arready=0 until final rlast.
// - Reset mid-burst after 2 of 4 beats -> m_axi_arvalid=0, s_axi_arready=1
//   next cycle; fresh burst completes correctly.

Source files
------------

// File: rtl/svc_axi_rd_burst_split_if.sv
// AXI4 read-channel bundle (AR + R) shared by the splitter's upstream and downstream ports.
// The slave modport faces the manager; the master modport faces the subordinate.
interface svc_axi_rd_burst_split_if #(
   parameter int unsigned AW  = 8,
   parameter int unsigned DW  = 16,
   parameter int unsigned IDW = 4
);
   logic           arvalid;
   logic [IDW-1:0] arid;
   logic [AW-1:0]  araddr;
   logic [7:0]     arlen;
   logic [2:0]     arsize;
   logic [1:0]     arburst;
   logic           arready;
   logic           rvalid;
   logic [IDW-1:0] rid;
   logic [DW-1:0]  rdata;
   logic [1:0]     rresp;
   logic           rlast;
   logic           rready;

   modport slave (
      input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
      output arready, rvalid, rid, rdata, rresp, rlast
   );

   modport master (
      output arvalid, arid, araddr, arlen, arsize, arburst, rready,
      input  arready, rvalid, rid, rdata, rresp, rlast
   );
endinterface

// File: rtl/svc_axi_rd_burst_split.sv
// Splits INCR read bursts into CHUNK_BEATS-aligned sub-bursts and merges the
// returning R beats back into one burst with a single rlast.
module svc_axi_rd_burst_split #(
   parameter int unsigned AXI_ADDR_WIDTH = 8,
   parameter int unsigned AXI_DATA_WIDTH = 16,
   parameter int unsigned AXI_ID_WIDTH   = 4,
   parameter int unsigned CHUNK_BEATS    = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   svc_axi_rd_burst_split_if.slave  s_axi,
   svc_axi_rd_burst_split_if.master m_axi
);
   localparam int unsigned AW         = AXI_ADDR_WIDTH;
   localparam int unsigned BPB        = AXI_DATA_WIDTH / 8;
   localparam int unsigned BEAT_SHIFT = $clog2(BPB);
   localparam int unsigned CW         = 9;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   // Beats until the next chunk boundary, capped by what is left of the burst.
   function automatic logic [CW-1:0] sub_beats(input logic [AW-1:0] addr, input logic [CW-1:0] rem);
      logic [AW-1:0] word;
      logic [CW-1:0] room;
      word = addr >> BEAT_SHIFT;
      room = CW'(CHUNK_BEATS) - CW'(word & AW'(CHUNK_BEATS - 1));
      return (rem < room) ? rem : room;
   endfunction

   state_t                  state, state_n;
   logic                    arready_q, arready_n;
   logic                    arvalid_q, arvalid_n;
   logic [AW-1:0]           addr_q, addr_n;
   logic [7:0]              len_q, len_n;
   logic [AXI_ID_WIDTH-1:0] id_q, id_n;
   logic [2:0]              size_q, size_n;
   logic [1:0]              burst_q, burst_n;
   logic [CW-1:0]           rem_q, rem_n;
   logic [CW-1:0]           issued_q, issued_n;
   logic [CW-1:0]           done_q, done_n;

   logic          ar_hs_c, m_ar_hs_c, m_rlast_hs_c, s_rlast_c, s_rlast_hs_c;
   logic [CW-1:0] cur_beats_c, nxt_rem_c, req_beats_c, first_beats_c, nxt_beats_c;
   logic [AW-1:0] nxt_addr_c;

   assign ar_hs_c       = s_axi.arvalid && arready_q;
   assign m_ar_hs_c     = arvalid_q && m_axi.arready;
   assign m_rlast_hs_c  = m_axi.rvalid && m_axi.rready && m_axi.rlast;
   assign s_rlast_c     = m_axi.rlast && (done_q == issued_q - CW'(1)) && (state != ISSUE);
   assign s_rlast_hs_c  = m_axi.rvalid && s_axi.rready && s_rlast_c;

   assign cur_beats_c   = CW'(len_q) + CW'(1);
   assign nxt_addr_c    = addr_q + AW'(32'(cur_beats_c) * BPB);
   assign nxt_rem_c     = rem_q - cur_beats_c;
   assign req_beats_c   = CW'(s_axi.arlen) + CW'(1);
   assign first_beats_c = sub_beats(s_axi.araddr, req_beats_c);
   assign nxt_beats_c   = sub_beats(nxt_addr_c, nxt_rem_c);

   // R channel is a straight pass-through except for the merged rlast.
   assign s_axi.rvalid  = m_axi.rvalid;
   assign s_axi.rid     = m_axi.rid;
   assign s_axi.rdata   = m_axi.rdata;
   assign s_axi.rresp   = m_axi.rresp;
   assign s_axi.rlast   = s_rlast_c;
   assign m_axi.rready  = s_axi.rready;

   assign s_axi.arready = arready_q;
   assign m_axi.arvalid = arvalid_q;
   assign m_axi.arid    = id_q;
   assign m_axi.araddr  = addr_q;
   assign m_axi.arlen   = len_q;
   assign m_axi.arsize  = size_q;
   assign m_axi.arburst = burst_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         arready_q <= 1'b0;
         arvalid_q <= 1'b0;
         addr_q    <= '0;
         len_q     <= '0;
         id_q      <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         rem_q     <= '0;
         issued_q  <= '0;
         done_q    <= '0;
      end else begin
         state     <= state_n;
         arready_q <= arready_n;
         arvalid_q <= arvalid_n;
         addr_q    <= addr_n;
         len_q     <= len_n;
         id_q      <= id_n;
         size_q    <= size_n;
         burst_q   <= burst_n;
         rem_q     <= rem_n;
         issued_q  <= issued_n;
         done_q    <= done_n;
      end
   end

   always_comb begin
      state_n   = state;
      arvalid_n = arvalid_q;
      addr_n    = addr_q;
      len_n     = len_q;
      id_n      = id_q;
      size_n    = size_q;
      burst_n   = burst_q;
      rem_n     = rem_q;
      issued_n  = issued_q;
      done_n    = m_rlast_hs_c ? done_q + CW'(1) : done_q;

      unique case (state)
         IDLE: begin
            if (ar_hs_c) begin
               id_n      = s_axi.arid;
               size_n    = s_axi.arsize;
               burst_n   = s_axi.arburst;
               addr_n    = s_axi.araddr;
               rem_n     = req_beats_c;
               len_n     = 8'(first_beats_c - CW'(1));
               arvalid_n = 1'b1;
               issued_n  = '0;
               done_n    = '0;
               state_n   = ISSUE;
            end
         end
         ISSUE: begin
            if (m_ar_hs_c) begin
               issued_n = issued_q + CW'(1);
               rem_n    = nxt_rem_c;
               if (nxt_rem_c == '0) begin
                  arvalid_n = 1'b0;
                  state_n   = s_rlast_hs_c ? IDLE : DRAIN;
               end else begin
                  addr_n = nxt_addr_c;
                  len_n  = 8'(nxt_beats_c - CW'(1));
               end
            end
         end
         DRAIN: begin
            if (s_rlast_hs_c) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      arready_n = (state_n == IDLE);
   end
endmodule
